alu_seq: RTL and testbench

- Registered, parametrised successor to the team's combinational 8-bit ALU.
- Keeps the same 4-bit opcode map. Adds a valid/ready handshake on input and output, a registered result and flag set, and an iterative shift-add multiplier that returns the full double-width product.
- Sits between the operand bus and the register file. The datapath controller issues one operation at a time.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_mul_iter.sv | 74 +++++++
 rtl/alu_seq.sv | 208 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the sequential ALU (alu_seq):
//   - 4-bit opcode map, identical to the earlier combinational 8-bit ALU.
//   - Controller state encoding.
//   Optional feature macro used by alu_seq: ALU_SAT_EN (saturating ADD/SUB).
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] ALU_MUL  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_NAND = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_ROR  = 4'b1010;
  localparam logic [3:0] ALU_ROL  = 4'b1011;
  localparam logic [3:0] ALU_NOT  = 4'b1100;
  localparam logic [3:0] ALU_SHL  = 4'b1101;
  localparam logic [3:0] ALU_SHR  = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// -----------------------------------------------------------------------------
// alu_mul_iter
//   Iterative unsigned shift-add multiplier, one partial product per cycle.
//   The first partial product is folded into the start cycle, so the full
//   2*WIDTH product is ready (done=1) WIDTH-1 cycles after start.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset (aborts a running multiply)
//   start    load operands and begin (ignored semantics while busy are the
//            caller's responsibility)
//   a, b     multiplicand / multiplier, WIDTH bits
//   busy     a multiply is in progress (includes the done cycle)
//   done     product valid this cycle; busy drops on the next edge
//   product  2*WIDTH-bit accumulator
// -----------------------------------------------------------------------------
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic               step;

  // cnt counts partial products already accumulated.
  assign done    = busy && (cnt == LAST);
  assign step    = busy && (cnt != LAST);
  assign product = acc;

  // Control: reset applies here only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CNT_W'(1);
    end else if (done) begin
      busy <= 1'b0;
    end else if (busy) begin
      cnt  <= cnt + 1'b1;
    end
  end

  // Datapath: start already applies bit 0 of the multiplier.
  always_ff @(posedge clk) begin
    if (start) begin
      acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier <= {1'b0, b[WIDTH-1:1]};
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//   Registered ALU with valid/ready handshakes. Single-cycle ops produce a
//   result the cycle after accept; MUL uses alu_mul_iter and produces the
//   full double-width product WIDTH+1 cycles after accept. One operation is
//   in flight at a time: IDLE -> (MUL) -> DONE -> IDLE.
//
//   Optional feature: define ALU_SAT_EN to make ADD saturate to all-ones on
//   carry and SUB clamp to zero on borrow (flags still report the raw
//   carry/borrow/overflow). Default build wraps modulo 2^WIDTH.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid / in_ready    request handshake (in_ready only in IDLE)
//   inst, a, b             opcode and operands, sampled at accept
//   out_valid / out_ready  result handshake (out_valid only in DONE)
//   result, result_hi      low result, upper product half (MUL only)
//   flag_z/s/c/v           zero, sign, carry/borrow, signed overflow
// -----------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       inst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_s,
  output logic             flag_c,
  output logic             flag_v
);

  state_t state, state_nxt;

  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic               load_alu;
  logic               load_mul;

  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               alu_def;

  // ADD result after optional saturation.
  function automatic logic [WIDTH-1:0] add_fix(input logic [WIDTH:0] s);
`ifdef ALU_SAT_EN
    return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
`else
    return s[WIDTH-1:0];
`endif
  endfunction

  // SUB result after optional clamping; bit WIDTH of d is the borrow.
  function automatic logic [WIDTH-1:0] sub_fix(input logic [WIDTH:0] d);
`ifdef ALU_SAT_EN
    return d[WIDTH] ? {WIDTH{1'b0}} : d[WIDTH-1:0];
`else
    return d[WIDTH-1:0];
`endif
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (inst == ALU_MUL) begin
            mul_start = 1'b1;
            state_nxt = MUL;
          end else begin
            load_alu  = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      MUL: begin
        if (mul_done) begin
          load_mul  = 1'b1;
          state_nxt = DONE;
        end else if (!mul_busy) begin
          // Multiplier not running: nothing will ever complete, recover.
          state_nxt = IDLE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: single-cycle datapath from the live operands at accept.
  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_def = 1'b1;
    case (inst)
      ALU_ADD: begin
        alu_res = add_fix(sum_w);
        alu_c   = sum_w[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = sub_fix(diff_w);
        alu_c   = diff_w[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND:  alu_res = a & b;
      ALU_NAND: alu_res = ~(a & b);
      ALU_OR:   alu_res = a | b;
      ALU_NOR:  alu_res = ~(a | b);
      ALU_NOT:  alu_res = ~a;
      ALU_ROR: begin
        alu_res = {a[0], a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      ALU_ROL: begin
        alu_res = {a[WIDTH-2:0], a[WIDTH-1]};
        alu_c   = a[WIDTH-1];
      end
      ALU_SHL: begin
        alu_res = {a[WIDTH-2:0], 1'b0};
        alu_c   = a[WIDTH-1];
      end
      ALU_SHR: begin
        alu_res = {1'b0, a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      // Undefined opcodes (and MUL, which never loads from here).
      default: alu_def = 1'b0;
    endcase
  end

  // Stage p1: registered result and flags, held through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      result_hi <= '0;
      flag_z    <= 1'b0;
      flag_s    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
    end else if (load_alu) begin
      result    <= alu_res;
      result_hi <= '0;
      // Undefined opcodes report result 0 with every flag clear, Z included.
      flag_z    <= alu_def && (alu_res == '0);
      flag_s    <= alu_res[WIDTH-1];
      flag_c    <= alu_c;
      flag_v    <= alu_v;
    end else if (load_mul) begin
      result    <= mul_prod[WIDTH-1:0];
      result_hi <= mul_prod[2*WIDTH-1:WIDTH];
      flag_z    <= (mul_prod == '0);
      flag_s    <= mul_prod[WIDTH-1];
      flag_c    <= |mul_prod[2*WIDTH-1:WIDTH];
      flag_v    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
//   Directed self-checking bench for alu_seq at WIDTH=8. Expected values are
//   hand-computed constants; with ALU_SAT_EN defined the saturated
//   expectations are selected. Flags are compared as {z,s,c,v}.
// -----------------------------------------------------------------------------
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   inst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         flag_z, flag_s, flag_c, flag_v;
  logic [3:0]   flags;

  int n_chk = 0;
  int n_err = 0;

  int   lat;
  logic rdy_seen;

`ifdef ALU_SAT_EN
  localparam logic [W-1:0] E_ADD_C = 8'hFF;
  localparam logic [3:0]   F_ADD_C = 4'b0110;
  localparam logic [W-1:0] E_SUB_B = 8'h00;
  localparam logic [3:0]   F_SUB_B = 4'b1010;
`else
  localparam logic [W-1:0] E_ADD_C = 8'h10;
  localparam logic [3:0]   F_ADD_C = 4'b0010;
  localparam logic [W-1:0] E_SUB_B = 8'hFE;
  localparam logic [3:0]   F_SUB_B = 4'b0110;
`endif

  assign flags = {flag_z, flag_s, flag_c, flag_v};

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inst      (inst),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flag_z    (flag_z),
    .flag_s    (flag_s),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one op; lat=1 means out_valid high right after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       output int l, output logic rdy);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    inst = op; a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Operands are free to change after accept.
    inst = ALU_AND; a = ~xa; b = ~xb;
    l = 1;
    rdy = in_ready;
    while (!out_valid && l < 50) begin
      @(posedge clk); #1;
      l++;
      rdy |= in_ready;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    inst = 4'h0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_result_hi", result_hi, 0);
    check("rst_flags", flags, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD with carry
    issue(ALU_ADD, 8'hF0, 8'h20, lat, rdy_seen);
    check("add_c_lat", lat, 1);
    check("add_c_res", result, E_ADD_C);
    check("add_c_flags", flags, F_ADD_C);
    check("add_c_rdy", rdy_seen, 0);
    consume();

    // SUB equal
    issue(ALU_SUB, 8'h05, 8'h05, lat, rdy_seen);
    check("sub_eq_res", result, 8'h00);
    check("sub_eq_flags", flags, 4'b1000);
    consume();

    // SUB with borrow
    issue(ALU_SUB, 8'h03, 8'h05, lat, rdy_seen);
    check("sub_b_res", result, E_SUB_B);
    check("sub_b_flags", flags, F_SUB_B);
    consume();

    // MUL 0x10*0x20 = 0x0200
    issue(ALU_MUL, 8'h10, 8'h20, lat, rdy_seen);
    check("mul_lat", lat, 9);
    check("mul_rdy", rdy_seen, 0);
    check("mul_res", result, 8'h00);
    check("mul_hi", result_hi, 8'h02);
    check("mul_flags", flags, 4'b0010);
    consume();

    // ROR 0x01
    issue(ALU_ROR, 8'h01, 8'h00, lat, rdy_seen);
    check("ror_res", result, 8'h80);
    check("ror_hi", result_hi, 8'h00);
    check("ror_flags", flags, 4'b0110);
    consume();

    // SHL 0x81
    issue(ALU_SHL, 8'h81, 8'h00, lat, rdy_seen);
    check("shl_res", result, 8'h02);
    check("shl_flags", flags, 4'b0010);
    consume();

    // ADD signed overflow, then hold out_ready low
    issue(ALU_ADD, 8'h7F, 8'h01, lat, rdy_seen);
    check("add_v_res", result, 8'h80);
    check("add_v_flags", flags, 4'b0101);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_res", result, 8'h80);
      check("hold_flags", flags, 4'b0101);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    consume();
    check("rel_out_valid", out_valid, 0);
    check("rel_in_ready", in_ready, 1);

    // Undefined opcode
    issue(4'b1111, 8'hFF, 8'hFF, lat, rdy_seen);
    check("undef_lat", lat, 1);
    check("undef_res", result, 8'h00);
    check("undef_flags", flags, 4'b0000);
    consume();

    // NAND
    issue(ALU_NAND, 8'hFF, 8'h0F, lat, rdy_seen);
    check("nand_res", result, 8'hF0);
    check("nand_flags", flags, 4'b0100);
    consume();

    // MUL 0xFF*0xFF = 0xFE01, with a stray request while busy
    fork
      issue(ALU_MUL, 8'hFF, 8'hFF, lat, rdy_seen);
      begin
        repeat (3) @(posedge clk);
        #2;
        in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
      end
    join
    check("mul2_lat", lat, 9);
    check("mul2_res", result, 8'h01);
    check("mul2_hi", result_hi, 8'hFE);
    check("mul2_flags", flags, 4'b0010);
    consume();

    // Reset on MUL cycle 4 aborts
    issue_start_only();
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_result", result, 0);
    check("abort_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(ALU_ADD, 8'h01, 8'h01, lat, rdy_seen);
    check("post_rst_lat", lat, 1);
    check("post_rst_res", result, 8'h02);
    check("post_rst_flags", flags, 4'b0000);
    consume();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Accept a MUL and return on the 4th MUL cycle, result not yet valid.
  task automatic issue_start_only();
    inst = ALU_MUL; a = 8'h10; b = 8'h20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_pre_busy", in_ready, 0);
  endtask

endmodule
